// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle unsigned divider.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 8;
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational iteration of the restoring division: shift, trial subtract, restore.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quot,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next_c,
    output logic [WIDTH-1:0] quot_next_c
);

    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] trial;
    logic           trial_neg;

    assign rem_shift = {rem, quot[WIDTH-1]};
    assign trial     = rem_shift - {1'b0, divisor};

    // rem < divisor holds between steps, so the top bit of the trial is its sign
    assign trial_neg = trial[WIDTH];

    assign rem_next_c  = trial_neg ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quot_next_c = {quot[WIDTH-2:0], ~trial_neg};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle unsigned restoring divider feeding the ALU div_out operand.
module div_unit
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] div_out,
    output logic [WIDTH-1:0] div_rem,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    div_state_t       state_q, state_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dsor_q, dsor_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] out_d, rem_out_d;
    logic             dbz_d, busy_d, done_d;
    logic [WIDTH-1:0] step_rem_c, step_quot_c;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem         (rem_q),
        .quot        (quot_q),
        .divisor     (dsor_q),
        .rem_next_c  (step_rem_c),
        .quot_next_c (step_quot_c)
    );

    // Next-state, datapath and output update logic
    always_comb begin
        state_d   = state_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        dsor_d    = dsor_q;
        cnt_d     = cnt_q;
        out_d     = div_out;
        rem_out_d = div_rem;
        dbz_d     = div_by_zero;

        unique case (state_q)
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    quot_d = step_quot_c;
                    rem_d  = step_rem_c;
                    if (cnt_q == '0) begin
                        state_d   = FIN;
                        out_d     = step_quot_c;
                        rem_out_d = step_rem_c;
                        dbz_d     = 1'b0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            IDLE, FIN: begin
                state_d = IDLE;
                if (!flush && start) begin
                    if (divisor != '0) begin
                        state_d = CALC;
                        quot_d  = dividend;
                        rem_d   = '0;
                        dsor_d  = divisor;
                        cnt_d   = CNT_W'(WIDTH - 1);
                    end else begin
                        // Divide by zero resolves immediately with a fixed result
                        state_d   = FIN;
                        out_d     = WIDTH'(DIV_ZERO_QUOT);
                        rem_out_d = dividend;
                        dbz_d     = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == CALC);
        done_d = (state_d == FIN);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            quot_q      <= '0;
            rem_q       <= '0;
            dsor_q      <= '0;
            cnt_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_out     <= '0;
            div_rem     <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state_q     <= state_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
            dsor_q      <= dsor_d;
            cnt_q       <= cnt_d;
            busy        <= busy_d;
            done        <= done_d;
            div_out     <= out_d;
            div_rem     <= rem_out_d;
            div_by_zero <= dbz_d;
        end
    end

endmodule
